// File: rtl/umul_seq.sv
// Iterative shift-add unsigned multiplier: one shared 2W-bit adder, W steps, saturated result.
// Optional build macro UMUL_SEQ_EARLY_EXIT_EN ends the step loop once the remaining multiplier bits are zero.
module umul_seq #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  sig_ov,
  output logic                  busy
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned AW    = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [AW-1:0]    r_mcand;
  logic [W-1:0]     r_mplier;
  logic [AW-1:0]    r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_out;
  logic             r_ov;
  logic             r_out_valid;

  logic [W-1:0]     w_mplier_shr;
  logic [AW-1:0]    w_addend;
  logic [AW-1:0]    w_acc_sum;
  logic             w_last;
  logic             w_accept;
  logic             w_sum_ov;

  // One step of the shared adder plus the loop-termination decision.
  always_comb begin
    w_mplier_shr = r_mplier >> 1;
    w_addend     = r_mplier[0] ? r_mcand : '0;
    w_acc_sum    = r_acc + w_addend;
    w_sum_ov     = |w_acc_sum[AW-1:W];
`ifdef UMUL_SEQ_EARLY_EXIT_EN
    w_last = (r_cnt == CNT_W'(W - 1)) || (w_mplier_shr == '0);
`else
    w_last = (r_cnt == CNT_W'(W - 1));
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand capture, per-step datapath update and result registration on DONE entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_ov        <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand  <= AW'(in0);
            r_mplier <= in1;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_sum;
          r_mcand  <= {r_mcand[AW-2:0], 1'b0};
          r_mplier <= w_mplier_shr;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_ov        <= w_sum_ov;
            r_out       <= w_sum_ov ? '1 : w_acc_sum[W-1:0];
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Handshake/status flags come only from the state register; in_ready is masked during reset.
  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign busy      = (r_state == S_BUSY);
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign sig_ov    = r_ov;

endmodule

// File: tb/tb_umul_seq.sv
// Self-checking bench for umul_seq (W=8): directed cases plus random operands against an arithmetic model.
module tb_umul_seq;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         sig_ov;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  umul_seq #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in0      (in0),
    .in1      (in1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .sig_ov   (sig_ov),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: full-precision product, saturate when it exceeds W bits.
  function automatic logic [W-1:0] model_out(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned p;
    longint unsigned lim;
    p   = longint'(a) * longint'(b);
    lim = (64'd1 << W) - 1;
    return (p > lim) ? W'(lim) : W'(p);
  endfunction

  function automatic logic model_ov(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p >= (64'd1 << W);
  endfunction

  function automatic int model_lat(input logic [W-1:0] b);
`ifdef UMUL_SEQ_EARLY_EXIT_EN
    int l;
    logic [W-1:0] v;
    l = 1;
    v = b;
    for (int i = 0; i < int'(W); i++) begin
      if (v[i]) l = i + 1;
    end
    return l;
`else
    return int'(W);
`endif
  endfunction

  // One transaction; all sampling happens 1 time unit after a rising edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                        input bit pre_ready, input bit toggle, input string tag);
    int guard;
    int lat;
    int nbusy;
    logic [W-1:0] held;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, "_in_ready"}, in_ready, 1);
    in0       = a;
    in1       = b;
    in_valid  = 1'b1;
    out_ready = pre_ready;
    @(posedge clk); #1;
    if (!toggle) in_valid = 1'b0;
    check({tag, "_busy_after_accept"}, busy, 1);
    check({tag, "_ready_low_busy"}, in_ready, 0);
    lat   = 0;
    nbusy = 1;
    while (!out_valid && lat < 3 * int'(W)) begin
      if (toggle) begin
        in0 = W'($urandom);
        in1 = W'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (busy) nbusy++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(model_lat(b)));
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'(model_lat(b)));
    check({tag, "_out"}, out, model_out(a, b));
    check({tag, "_ov"}, sig_ov, model_ov(a, b));
    held = out;
    if (!pre_ready) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check({tag, "_hold_valid"}, out_valid, 1);
        check({tag, "_hold_out"}, out, held);
        check({tag, "_hold_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
    check({tag, "_out_kept"}, out, held);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    int ovseen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in0       = '0;
    in1       = '0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out", out, 0);
    check("rst_ov", sig_ov, 0);
    #20 rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    run_op(8'd12, 8'd10, 0, 1'b1, 1'b0, "m12x10");
    run_op(8'd15, 8'd17, 0, 1'b1, 1'b0, "m15x17");
    run_op(8'd16, 8'd16, 0, 1'b0, 1'b0, "m16x16");
    run_op(8'd255, 8'd255, 1, 1'b0, 1'b0, "m255x255");
    run_op(8'd3, 8'd7, 5, 1'b0, 1'b0, "m3x7_stall");
    run_op(8'd9, 8'd9, 0, 1'b0, 1'b1, "m9x9_toggle");
    run_op(8'd200, 8'd1, 0, 1'b1, 1'b0, "m200x1");
    run_op(8'd3, 8'd0, 0, 1'b1, 1'b0, "m3x0");
    run_op(8'd1, 8'd128, 0, 1'b1, 1'b0, "m1x128");
    run_op(8'd2, 8'd128, 0, 1'b1, 1'b0, "m2x128");

    // Asynchronous reset in the middle of BUSY discards the operation.
    in0      = 8'd100;
    in1      = 8'd200;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out", out, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("abort_release_ready", in_ready, 1);
    ovseen = 0;
    for (int i = 0; i < 2 * int'(W); i++) begin
      @(posedge clk); #1;
      if (out_valid) ovseen++;
    end
    check("abort_no_valid", 64'(ovseen), 0);
    run_op(8'd6, 8'd5, 0, 1'b0, 1'b0, "m6x5_after_rst");

    for (int k = 0; k < 24; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (k % 4 == 0) rb = W'(1 << (k % 8));
      run_op(ra, rb, int'($urandom_range(0, 3)), 1'(k % 2), 1'(k % 3 == 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/umul_seq.md
# umul_seq

Iterative shift-add controller for unsigned multiplication: accepts one operand pair over a valid/ready handshake, sequences `DATA_WIDTH` conditional-add steps through a single shared `2*DATA_WIDTH`-bit adder, then presents a saturated product with an overflow flag. It sits in the math library beside the combinational multiplier. It is the area-optimised option for datapaths that can tolerate multi-cycle latency. A single adder replaces the `DATA_WIDTH`-deep partial-product tree.

## Interface
- `DATA_WIDTH`, default 8: width of `in0`, `in1`, `out`; legal range 2..64.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair on `in0`/`in1` is valid.
- `in_ready`  out  1  block can accept an operand pair.
- `in0`  in  `DATA_WIDTH`  multiplicand, unsigned.
- `in1`  in  `DATA_WIDTH`  multiplier, unsigned.
- `out_valid`  out  1  result on `out`/`sig_ov` is valid.
- `out_ready`  in  1  downstream accepts the result.
- `out`  out  `DATA_WIDTH`  saturated product, unsigned.
- `sig_ov`  out  1  product does not fit in `DATA_WIDTH` bits.
- `busy`  out  1  state is BUSY.

## Operation
- State machine: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready` = 1 while `rst` is low.
  - On `in_valid && in_ready`, register these values and go to BUSY:
    - `mcand` = zero-extended `in0` (2W bits).
    - `mplier` = `in1` (W bits).
    - `acc` = 0.
    - `cnt` = 0.
  - Inputs are sampled only at acceptance; later changes to them are ignored.
- BUSY, one step per cycle:
  - If `mplier[0]`, then `acc` += `mcand`.
  - `mcand` <<= 1; `mplier` >>= 1; `cnt` += 1.
  - When `cnt == DATA_WIDTH-1` at the step, go to DONE.
  - `acc` is 2W bits wide and never wraps, because the product is less than 2^(2W).
- DONE entry, registered:
  - `sig_ov` = |`acc[2W-1:W]`.
  - `out` = `sig_ov` ? all-ones : `acc[W-1:0]`.
  - `out_valid` = 1.
- DONE:
  - Hold `out_valid`, `out` and `sig_ov` stable until `out_ready`.
  - On `out_valid && out_ready`, go to IDLE. `out_valid` falls at that edge.
  - No acceptance is possible in DONE. The next operand is accepted in IDLE at the earliest one cycle later.
- `out`/`sig_ov` keep the last result after the handshake, until the next DONE entry.
- Reset values: `in_ready`=0 while `rst` is high and 1 after release; all other outputs are 0.
- Reset asserted mid-operation aborts the operation immediately, with no `out_valid`. The in-flight result is discarded.

## Timing
- Acceptance edge = E0. Without early exit, BUSY occupies W cycles and DONE is entered at edge E0+W. `out_valid` is high from E0+W.
- Minimum issue interval: W+2 cycles. This covers accept, W steps, and a DONE cycle with `out_ready` high, followed by IDLE.
- `in_ready` and `busy` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- `out_ready` high on the first DONE cycle completes the handshake in that cycle.

## Configuration
- `UMUL_SEQ_EARLY_EXIT_EN` defined:
  - BUSY also exits to DONE when the post-shift `mplier` is zero.
  - Latency becomes max(1, index of the highest set bit of `in1` + 1) cycles.
  - For example, `in1`=0 or 1 gives latency 1, and `in1`=0x80 gives latency 8 when W=8.
  - Results are identical in both builds.
- Macro not defined: latency is always exactly `DATA_WIDTH` cycles, independent of operands.

## Test plan
- W=8, 12×10 -> `out`=120, `sig_ov`=0, `out_valid` high exactly 8 edges after acceptance. `busy` is high for 8 cycles.
- W=8, 15×17 -> `out`=255, `sig_ov`=0. Then 16×16 -> `out`=255, `sig_ov`=1. Then 255×255 -> `out`=255, `sig_ov`=1.
- W=8, 3×7 with `out_ready` low for 5 cycles in DONE:
  - `out`=21 stays stable and `in_ready`=0 throughout.
  - Raising `out_ready` drops `out_valid` at the next edge.
  - `in_ready` rises in the following cycle.
- W=8, `in0` and `in1` toggled randomly after acceptance of 9×9 -> `out`=81 unaffected. `in_valid` held high through BUSY causes no second acceptance.
- W=8, `rst` pulsed asynchronously mid-BUSY (cycle 4):
  - Outputs go to their reset values immediately.
  - No `out_valid` appears.
  - After release, 6×5 -> `out`=30 after 8 edges.
- With `UMUL_SEQ_EARLY_EXIT_EN`, W=8:
  - 200×1 -> `out`=200 after 1 edge.
  - 3×0 -> `out`=0 after 1 edge.
  - 1×128 -> `out`=128 after 8 edges.
  - 2×128 -> `out`=255, `sig_ov`=1 after 8 edges.
